circuit_2: RTL and testbench

CIRCUIT_2 -- requirements
Module: circuit_2

---
 rtl/circuit_2_if.sv | 24 ++
 rtl/circuit_2.sv | 48 ++++
 tb/tb_circuit_2.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/circuit_2_if.sv
// Operand/result bundle for circuit_2: four function operands in, the
// combinational result plus its registered status outputs back.
interface circuit_2_if;
    localparam int unsigned CNT_W = 5;

    logic             x;
    logic             y;
    logic             w;
    logic             z;
    logic             f;
    logic             f_q;
    logic             f_rise;
    logic [CNT_W-1:0] hit_cnt;

    modport master (
        output x, y, w, z,
        input  f, f_q, f_rise, hit_cnt
    );

    modport slave (
        input  x, y, w, z,
        output f, f_q, f_rise, hit_cnt
    );
endinterface

// File: rtl/circuit_2.sv
// Four-input Boolean function with a registered copy, a registered rising-edge
// pulse of that copy and a saturating count of cycles where the copy is high.
module circuit_2 (
    input  logic        clk,
    input  logic        rst,
    circuit_2_if.slave  bus
);
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             f_q_r,    f_q_nxt;
    logic             f_q_d_r,  f_q_d_nxt;
    logic             rise_r,   rise_nxt;
    logic [CNT_W-1:0] cnt_r,    cnt_nxt;

    // Pure combinational function; independent of clk and rst.
    assign bus.f = (bus.x & bus.y) | (~bus.y & bus.z) | (bus.w & ~bus.z);

    // The pulse is taken from f_q against its own one-cycle-old copy, so it
    // lands one edge after f_q itself rises.
    always_comb begin
        f_q_nxt   = bus.f;
        f_q_d_nxt = f_q_r;
        rise_nxt  = f_q_r & ~f_q_d_r;
        cnt_nxt   = cnt_r;
        if (f_q_r && (cnt_r != CNT_MAX)) begin
            cnt_nxt = cnt_r + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q_r   <= 1'b0;
            f_q_d_r <= 1'b0;
            rise_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            f_q_r   <= f_q_nxt;
            f_q_d_r <= f_q_d_nxt;
            rise_r  <= rise_nxt;
            cnt_r   <= cnt_nxt;
        end
    end

    assign bus.f_q     = f_q_r;
    assign bus.f_rise  = rise_r;
    assign bus.hit_cnt = cnt_r;
endmodule

// File: tb/tb_circuit_2.sv
// Self-checking bench for circuit_2: truth-table sweep, vector table,
// directed multi-cycle sequences and randomized traffic against a history model.
module tb_circuit_2;
    logic clk;
    logic rst;

    circuit_2_if bus ();

    circuit_2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Minterms 1,2,3,6,9..15 are ones.
    logic [15:0] f_tab = 16'hFE4E;

    // Values of f sampled at each non-reset edge since the last reset.
    bit hist[$];

    typedef struct {
        bit         r;
        logic [3:0] v;
        bit         e_fq;
        bit         e_rise;
        int         e_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // f_q after k edges since reset.
    function automatic bit mq(input int k);
        if (k <= 0 || k > hist.size()) return 1'b0;
        return hist[k-1];
    endfunction

    task automatic check_all(input string tag);
        int k;
        int ones;
        k = hist.size();
        ones = 0;
        for (int j = 1; j < k; j++) ones += int'(mq(j));
        if (ones > 31) ones = 31;
        chk({tag, " f_q"},     32'(bus.f_q),     32'(mq(k)));
        chk({tag, " f_rise"},  32'(bus.f_rise),  32'(mq(k-1) & ~mq(k-2)));
        chk({tag, " hit_cnt"}, 32'(bus.hit_cnt), 32'(ones));
    endtask

    task automatic tick(input bit r, input logic [3:0] v);
        rst = r;
        {bus.x, bus.y, bus.w, bus.z} = v;
        @(posedge clk);
        #1;
        if (r) hist.delete();
        else   hist.push_back(f_tab[v]);
    endtask

    initial begin
        bit   exp_sweep [16];
        vec_t vecs [10];
        logic [3:0] v;
        bit   r;

        exp_sweep = '{0,1,1,1,0,0,1,0,0,1,1,1,1,1,1,1};
        rst = 1'b0;
        {bus.x, bus.y, bus.w, bus.z} = 4'b0000;

        // Exhaustive combinational sweep; rst toggled to show it has no effect on f.
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            {bus.x, bus.y, bus.w, bus.z} = v;
            rst = v[0];
            #1;
            chk($sformatf("sweep f[%0d]", i), 32'(bus.f), 32'(exp_sweep[i]));
            #9;
        end

        @(negedge clk);

        // Hand-computed vector table: first-hit latency, pulse timing, reset with f_rise high.
        vecs[0] = '{1'b1, 4'b1100, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b0, 4'b1100, 1'b1, 1'b0, 0};
        vecs[2] = '{1'b0, 4'b1100, 1'b1, 1'b1, 1};
        vecs[3] = '{1'b0, 4'b1100, 1'b1, 1'b0, 2};
        vecs[4] = '{1'b0, 4'b0000, 1'b0, 1'b0, 3};
        vecs[5] = '{1'b0, 4'b0000, 1'b0, 1'b0, 3};
        vecs[6] = '{1'b0, 4'b0001, 1'b1, 1'b0, 3};
        vecs[7] = '{1'b0, 4'b0100, 1'b0, 1'b1, 4};
        vecs[8] = '{1'b1, 4'b1111, 1'b0, 1'b0, 0};
        vecs[9] = '{1'b0, 4'b1111, 1'b1, 1'b0, 0};
        for (int i = 0; i < 10; i++) begin
            tick(vecs[i].r, vecs[i].v);
            chk($sformatf("vec%0d f_q", i),     32'(bus.f_q),     32'(vecs[i].e_fq));
            chk($sformatf("vec%0d f_rise", i),  32'(bus.f_rise),  32'(vecs[i].e_rise));
            chk($sformatf("vec%0d hit_cnt", i), 32'(bus.hit_cnt), 32'(vecs[i].e_cnt));
        end

        // Saturation, then reset while saturated.
        tick(1'b1, 4'b1111);
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 4'b1111);
            check_all($sformatf("sat%0d", i));
        end
        chk("sat final", 32'(bus.hit_cnt), 32'd31);
        tick(1'b1, 4'b1111);
        chk("sat rst f_q",     32'(bus.f_q),     32'd0);
        chk("sat rst hit_cnt", 32'(bus.hit_cnt), 32'd0);

        // Reset at hit_cnt=17 with input held at 1111.
        for (int i = 0; i < 18; i++) tick(1'b0, 4'b1111);
        chk("pre17 hit_cnt", 32'(bus.hit_cnt), 32'd17);
        tick(1'b1, 4'b1111);
        chk("r17 f_q",     32'(bus.f_q),     32'd0);
        chk("r17 f_rise",  32'(bus.f_rise),  32'd0);
        chk("r17 hit_cnt", 32'(bus.hit_cnt), 32'd0);
        tick(1'b0, 4'b1111);
        chk("r17 next f_q", 32'(bus.f_q), 32'd1);

        // Alternate 0000/0001 every edge.
        tick(1'b1, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, (i % 2 == 0) ? 4'b0001 : 4'b0000);
            check_all($sformatf("alt%0d", i));
        end

        // Inputs changed between edges: only f moves until the next edge.
        tick(1'b0, 4'b0000);
        check_all("mid pre");
        #2;
        {bus.x, bus.y, bus.w, bus.z} = 4'b1111;
        #1;
        chk("mid f", 32'(bus.f), 32'd1);
        check_all("mid hold");
        {bus.x, bus.y, bus.w, bus.z} = 4'b0100;
        #1;
        chk("mid f2", 32'(bus.f), 32'd0);
        check_all("mid hold2");
        tick(1'b0, 4'b1111);
        check_all("mid post");

        // Randomized traffic against the history model.
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 24) == 0);
            v = 4'($urandom_range(0, 15));
            tick(r, v);
            chk($sformatf("rnd%0d f", i), 32'(bus.f), 32'(f_tab[v]));
            check_all($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
